// File: rtl/magia_boot_sequencer_if.sv
// Handshake bundle between SoC control, the boot sequencer
// and the tile array enable/sleep lines.
interface magia_boot_sequencer_if #(
    parameter int N_TILES   = 4,
    parameter int STAGGER_W = 8,
    parameter int TIMEOUT_W = 16
);
    logic                 start_i;
    logic                 abort_i;
    logic [STAGGER_W-1:0] stagger_cycles_i;
    logic [TIMEOUT_W-1:0] timeout_cycles_i;
    logic [N_TILES-1:0]   core_sleep_i;
    logic [N_TILES-1:0]   tile_enable_o;
    logic [N_TILES-1:0]   fetch_enable_o;
    logic [N_TILES-1:0]   tiles_done_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 timeout_o;

    modport master (
        output start_i,
        output abort_i,
        output stagger_cycles_i,
        output timeout_cycles_i,
        output core_sleep_i,
        input  tile_enable_o,
        input  fetch_enable_o,
        input  tiles_done_o,
        input  busy_o,
        input  done_o,
        input  timeout_o
    );

    modport slave (
        input  start_i,
        input  abort_i,
        input  stagger_cycles_i,
        input  timeout_cycles_i,
        input  core_sleep_i,
        output tile_enable_o,
        output fetch_enable_o,
        output tiles_done_o,
        output busy_o,
        output done_o,
        output timeout_o
    );
endinterface

// File: rtl/magia_boot_sequencer.sv
// MAGIA boot sequencer: enables all tiles, releases fetch enable
// one tile at a time, then watches core sleep for done/timeout.
module magia_boot_sequencer #(
    parameter int N_TILES   = 4,
    parameter int STAGGER_W = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    magia_boot_sequencer_if.slave bus_if
);
    localparam int KW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_TILES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENABLE,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t               state_q;
    logic [N_TILES-1:0]   fetch_q;
    logic [N_TILES-1:0]   armed_q;
    logic [N_TILES-1:0]   tdone_q;
    logic [STAGGER_W-1:0] stagger_q;
    logic [STAGGER_W-1:0] scnt_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [TIMEOUT_W-1:0] tcnt_q;
    logic [KW-1:0]        k_q;

    logic                 monitor;
    logic [N_TILES-1:0]   armed_d;
    logic [N_TILES-1:0]   tdone_d;
    logic [KW-1:0]        k_d;
    logic [TIMEOUT_W:0]   tcnt_inc;
    logic                 timeout_hit;

    // Completion tracking: a tile must be seen awake before its
    // sleep counts as done; also next tile index and timeout match.
    always_comb begin
        monitor     = (state_q == S_RELEASE) || (state_q == S_RUN);
        armed_d     = armed_q | (fetch_q & ~bus_if.core_sleep_i);
        tdone_d     = tdone_q | (armed_q & bus_if.core_sleep_i);
        k_d         = k_q + KW'(1);
        tcnt_inc    = {1'b0, tcnt_q} + (TIMEOUT_W+1)'(1);
        timeout_hit = (timeout_q != '0) &&
                      (tcnt_inc == {1'b0, timeout_q});
    end

    // Sequencing FSM with registered fetch enables and flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            fetch_q   <= '0;
            armed_q   <= '0;
            tdone_q   <= '0;
            stagger_q <= '0;
            timeout_q <= '0;
            scnt_q    <= '0;
            tcnt_q    <= '0;
            k_q       <= '0;
        end else if (bus_if.abort_i) begin
            state_q <= S_IDLE;
            fetch_q <= '0;
            armed_q <= '0;
            tdone_q <= '0;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            k_q     <= '0;
        end else begin
            if (monitor) begin
                armed_q <= armed_d;
                tdone_q <= tdone_d;
            end
            unique case (state_q)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (bus_if.start_i) begin
                        stagger_q <= bus_if.stagger_cycles_i;
                        timeout_q <= bus_if.timeout_cycles_i;
                        fetch_q   <= '0;
                        armed_q   <= '0;
                        tdone_q   <= '0;
                        scnt_q    <= '0;
                        tcnt_q    <= '0;
                        k_q       <= '0;
                        state_q   <= S_ENABLE;
                    end
                end
                S_ENABLE: begin
                    k_q        <= '0;
                    fetch_q[0] <= 1'b1;
                    scnt_q     <= stagger_q;
                    state_q    <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (scnt_q != '0) begin
                        scnt_q <= scnt_q - STAGGER_W'(1);
                    end else if (k_q != K_LAST) begin
                        k_q          <= k_d;
                        fetch_q[k_d] <= 1'b1;
                        scnt_q       <= stagger_q;
                    end else begin
                        tcnt_q  <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (&tdone_q) begin
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        state_q <= S_TIMEOUT;
                    end
                    if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_inc[TIMEOUT_W-1:0];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_if.tile_enable_o  = {N_TILES{state_q != S_IDLE}};
    assign bus_if.fetch_enable_o = fetch_q;
    assign bus_if.tiles_done_o   = tdone_q;
    assign bus_if.busy_o         = (state_q == S_ENABLE) ||
                                   (state_q == S_RELEASE) ||
                                   (state_q == S_RUN);
    assign bus_if.done_o         = (state_q == S_DONE);
    assign bus_if.timeout_o      = (state_q == S_TIMEOUT);
endmodule

// File: tb/tb_magia_boot_sequencer.sv
// Bench for magia_boot_sequencer: timeline-based reference model,
// per-cycle compare, directed scenarios and randomized runs.
module tb_magia_boot_sequencer;
    localparam int N  = 4;
    localparam int SW = 8;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    magia_boot_sequencer_if #(
        .N_TILES(N), .STAGGER_W(SW), .TIMEOUT_W(TW)
    ) bif ();

    magia_boot_sequencer #(
        .N_TILES(N), .STAGGER_W(SW), .TIMEOUT_W(TW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(bif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_ACT, M_DONE, M_TO} mode_t;
    mode_t       m_mode = M_IDLE;
    longint      edges  = 0;
    longint      t0     = 0;
    int          m_s    = 0;
    int          m_t    = 0;
    logic [N-1:0] m_arm  = '0;
    logic [N-1:0] m_done = '0;
    longint      ma, mr, mrun;
    logic [N-1:0] mfe, mna, mnd;

    // fetch enables after `a` edges since the start edge
    function automatic logic [N-1:0] fe_at(longint a, int s);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (a >= longint'(1 + i * (s + 1))) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE;
            m_arm  = '0;
            m_done = '0;
        end else begin
            if (bif.abort_i) begin
                m_mode = M_IDLE;
                m_arm  = '0;
                m_done = '0;
            end else if (m_mode == M_ACT) begin
                ma   = edges - 1 - t0;
                mrun = 1 + N * (m_s + 1);
                if (ma >= 1) begin
                    mfe = fe_at(ma, m_s);
                    mna = m_arm | (mfe & ~bif.core_sleep_i);
                    mnd = m_done | (m_arm & bif.core_sleep_i);
                    if (ma >= mrun) begin
                        mr = ma - mrun;
                        if (&m_done) m_mode = M_DONE;
                        else if (m_t != 0 && mr + 1 == m_t)
                            m_mode = M_TO;
                    end
                    m_arm  = mna;
                    m_done = mnd;
                end
            end else if (bif.start_i) begin
                t0     = edges;
                m_s    = int'(bif.stagger_cycles_i);
                m_t    = int'(bif.timeout_cycles_i);
                m_arm  = '0;
                m_done = '0;
                m_mode = M_ACT;
            end
            edges++;
        end
    end

    logic [14:0] c_exp, c_got;
    always @(negedge clk) begin
        case (m_mode)
            M_ACT:  c_exp = {{N{1'b1}},
                             fe_at(edges - 1 - t0, m_s),
                             m_done, 3'b100};
            M_DONE: c_exp = {{N{1'b1}}, {N{1'b1}}, m_done, 3'b010};
            M_TO:   c_exp = {{N{1'b1}}, {N{1'b1}}, m_done, 3'b001};
            default: c_exp = '0;
        endcase
        c_got = {bif.tile_enable_o, bif.fetch_enable_o,
                 bif.tiles_done_o, bif.busy_o, bif.done_o,
                 bif.timeout_o};
        chk("cycle", 32'(c_got), 32'(c_exp));
    end

    // ---------------- core behaviour model ----------------
    bit cm_en = 1'b1;
    int wake[N];
    int runl[N];
    int ccnt[N];

    task automatic set_cores(input int w, input int r);
        for (int i = 0; i < N; i++) begin
            wake[i] = w;
            runl[i] = r;
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (cm_en) begin
                for (int i = 0; i < N; i++) begin
                    if (bif.fetch_enable_o[i]) ccnt[i]++;
                    else ccnt[i] = 0;
                    bif.core_sleep_i[i] = !(wake[i] >= 0 &&
                        ccnt[i] > wake[i] &&
                        (runl[i] == 0 ||
                         ccnt[i] <= wake[i] + runl[i]));
                end
            end
        end
    endtask

    task automatic start_seq(input int s, input int t);
        bif.stagger_cycles_i = SW'(s);
        bif.timeout_cycles_i = TW'(t);
        bif.start_i = 1'b1;
        step(1);
        bif.start_i = 1'b0;
    endtask

    task automatic do_abort();
        bif.abort_i = 1'b1;
        step(1);
        bif.abort_i = 1'b0;
        step(1);
    endtask

    task automatic wait_end(input int maxc);
        int k;
        k = 0;
        while (!(bif.done_o || bif.timeout_o) && k < maxc) begin
            step(1);
            k++;
        end
        chk("wait_end", 32'(bif.done_o | bif.timeout_o), 32'd1);
    endtask

    int rlen;

    initial begin
        bif.start_i          = 1'b0;
        bif.abort_i          = 1'b0;
        bif.stagger_cycles_i = '0;
        bif.timeout_cycles_i = '0;
        bif.core_sleep_i     = '1;
        for (int i = 0; i < N; i++) ccnt[i] = 0;
        set_cores(3, 10);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'({bif.tile_enable_o,
            bif.fetch_enable_o, bif.tiles_done_o, bif.busy_o,
            bif.done_o, bif.timeout_o}), 32'd0);
        rst = 1'b0;
        step(2);

        // basic boot, stagger 2
        start_seq(2, 0);
        chk("boot_tile_en", 32'(bif.tile_enable_o), 32'hF);
        chk("boot_fe_en", 32'(bif.fetch_enable_o), 32'h0);
        step(1);
        chk("boot_fe_1", 32'(bif.fetch_enable_o), 32'h1);
        step(3);
        chk("boot_fe_2", 32'(bif.fetch_enable_o), 32'h3);
        step(3);
        chk("boot_fe_3", 32'(bif.fetch_enable_o), 32'h7);
        step(3);
        chk("boot_fe_4", 32'(bif.fetch_enable_o), 32'hF);
        wait_end(200);
        chk("boot_done", 32'(bif.done_o), 32'd1);
        chk("boot_busy", 32'(bif.busy_o), 32'd0);
        chk("boot_tdone", 32'(bif.tiles_done_o), 32'hF);

        // restart from DONE with a new stagger
        start_seq(1, 0);
        chk("rs_tdone", 32'(bif.tiles_done_o), 32'h0);
        chk("rs_fe", 32'(bif.fetch_enable_o), 32'h0);
        chk("rs_tile", 32'(bif.tile_enable_o), 32'hF);
        step(1);
        chk("rs_fe_1", 32'(bif.fetch_enable_o), 32'h1);
        step(2);
        chk("rs_fe_2", 32'(bif.fetch_enable_o), 32'h3);
        wait_end(200);
        do_abort();

        // stagger 0
        start_seq(0, 0);
        step(1);
        chk("s0_fe_1", 32'(bif.fetch_enable_o), 32'h1);
        step(1);
        chk("s0_fe_2", 32'(bif.fetch_enable_o), 32'h3);
        step(1);
        chk("s0_fe_3", 32'(bif.fetch_enable_o), 32'h7);
        step(1);
        chk("s0_fe_4", 32'(bif.fetch_enable_o), 32'hF);
        do_abort();

        // timeout: tile 3 never goes back to sleep
        set_cores(1, 3);
        runl[3] = 0;
        start_seq(1, 20);
        step(28);
        chk("to_early", 32'(bif.timeout_o), 32'd0);
        step(1);
        chk("to_hit", 32'(bif.timeout_o), 32'd1);
        chk("to_tdone", 32'(bif.tiles_done_o), 32'h7);
        chk("to_done", 32'(bif.done_o), 32'd0);
        do_abort();

        // done and timeout in the same cycle
        cm_en = 1'b0;
        bif.core_sleep_i = '0;
        start_seq(0, 6);
        step(9);
        bif.core_sleep_i = '1;
        step(1);
        chk("tie_busy", 32'(bif.busy_o), 32'd1);
        step(1);
        chk("tie_done", 32'(bif.done_o), 32'd1);
        chk("tie_to", 32'(bif.timeout_o), 32'd0);
        do_abort();
        cm_en = 1'b1;

        // abort mid-release with start held high
        set_cores(3, 10);
        start_seq(3, 0);
        step(5);
        chk("ab_fe", 32'(bif.fetch_enable_o), 32'h3);
        bif.abort_i = 1'b1;
        bif.start_i = 1'b1;
        step(1);
        chk("ab_out", 32'({bif.tile_enable_o,
            bif.fetch_enable_o, bif.busy_o}), 32'd0);
        step(1);
        chk("ab_hold", 32'({bif.tile_enable_o,
            bif.fetch_enable_o, bif.busy_o}), 32'd0);
        bif.abort_i = 1'b0;
        step(1);
        chk("ab_restart", 32'(bif.tile_enable_o), 32'hF);
        bif.start_i = 1'b0;
        do_abort();

        // asynchronous reset while in RUN
        set_cores(0, 0);
        start_seq(0, 0);
        step(8);
        chk("ar_busy", 32'(bif.busy_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_async", 32'({bif.tile_enable_o,
            bif.fetch_enable_o, bif.busy_o}), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("ar_idle", 32'({bif.tile_enable_o,
            bif.tiles_done_o, bif.busy_o}), 32'd0);

        // randomized runs
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                wake[i] = ($urandom_range(0, 7) == 0) ? -1 :
                          int'($urandom_range(0, 5));
                runl[i] = int'($urandom_range(0, 12));
            end
            start_seq(int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) == 0) ? 0 :
                      int'($urandom_range(1, 40)));
            rlen = int'($urandom_range(60, 160));
            for (int c = 0; c < rlen; c++) begin
                bif.stagger_cycles_i = SW'($urandom_range(0, 6));
                bif.timeout_cycles_i = TW'($urandom_range(0, 40));
                bif.start_i = ($urandom_range(0, 30) == 0);
                bif.abort_i = ($urandom_range(0, 90) == 0);
                step(1);
            end
            bif.start_i = 1'b0;
            do_abort();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/magia_boot_sequencer.md
Name: magia_boot_sequencer

Overview:
Mesh-level controller that brings MAGIA tiles out of idle in a controlled order. It asserts tile enable to all tiles, then releases per-tile fetch enable one tile at a time with a programmable stagger. It then monitors each core's sleep output to detect program completion and reports done or timeout. It sits between the SoC control and the tile_enable / fetch_enable inputs of the tile array, replacing the global broadcast of those signals.

Parameters:
N_TILES, 4, number of tiles sequenced (tile index = row*N_TILES_X + col)
STAGGER_W, 8, width of the stagger interval
TIMEOUT_W, 16, width of the completion timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  start request, level sampled each cycle
abort_i  in  1  abort; return to IDLE
stagger_cycles_i  in  STAGGER_W  cycles between successive fetch-enable releases; latched at start
timeout_cycles_i  in  TIMEOUT_W  completion timeout in cycles; 0 = disabled; latched at start
core_sleep_i  in  N_TILES  per-tile core sleep status
tile_enable_o  out  N_TILES  per-tile tile enable
fetch_enable_o  out  N_TILES  per-tile fetch enable
tiles_done_o  out  N_TILES  sticky per-tile completion flags
busy_o  out  1  high in ENABLE, RELEASE and RUN
done_o  out  1  high in DONE
timeout_o  out  1  high in TIMEOUT

Behaviour:
- Reset: state = IDLE; all outputs are 0; internal counters, latched config, armed[] and tiles_done are cleared.
- All outputs are registered or decoded from registered state. No combinational path from an input to an output.
- IDLE: when start_i = 1, latch stagger_cycles_i and timeout_cycles_i, then go to ENABLE.
- ENABLE (1 cycle): tile_enable_o is all 1s; fetch_enable_o is all 0s. Set k = 0 and go to RELEASE.
- RELEASE: on entry for tile k, set fetch_enable_o[k] = 1 and load scnt = stagger.
  - While scnt != 0, decrement scnt.
  - When scnt = 0 and k < N_TILES-1: increment k and release the next tile. Tile k+1 is released stagger+1 cycles after tile k.
  - When scnt = 0 and k = N_TILES-1: go to RUN.
  - With stagger = 0, one tile is released per cycle.
- Cycle timing (start_i high at edge t):
  - tile_enable_o is visible after edge t.
  - fetch_enable_o[0] is visible after edge t+1.
  - fetch_enable_o[i] is visible after edge t+1+i*(stagger+1).
- Completion detection, per tile, active in RELEASE and RUN:
  - armed[i] sets when fetch_enable_o[i] = 1 and core_sleep_i[i] = 0.
  - tiles_done_o[i] sets when armed[i] = 1 and core_sleep_i[i] = 1.
  - Both flags are sticky until the next start or abort.
  - A core that sleeps continuously from release without ever waking is never counted done.
- RUN: tcnt starts at 0 and increments each cycle, saturating at its maximum.
  - If tiles_done_o is all 1s, go to DONE.
  - Else if timeout != 0 and tcnt + 1 = timeout, go to TIMEOUT.
  - If both conditions hold in the same cycle, DONE wins.
- DONE and TIMEOUT: tile_enable_o and fetch_enable_o stay high; tiles_done_o holds its value.
  - start_i = 1 restarts: clear tiles_done, armed and counters, latch new config, go to ENABLE. fetch_enable_o is 0 during that ENABLE cycle.
- start_i in ENABLE, RELEASE or RUN is ignored.
- abort_i = 1 in any state: next state is IDLE and all outputs go to 0 on the next edge. abort_i has priority over start_i and over every other transition.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous), state returns to IDLE.

Test Plan:
- Basic boot: N_TILES=4, stagger=2, timeout=0. Pulse start at cycle 0; each core drops sleep 3 cycles after its release and raises it 10 cycles later. Expected: tile_enable 4'hF at cycle 1; fetch_enable bits rise at cycles 2, 5, 8, 11; done_o rises the cycle after the last tile sleeps; busy_o falls at the same time.
- Stagger 0: fetch_enable goes 4'b0001, 4'b0011, 4'b0111, 4'b1111 on consecutive cycles 2 to 5.
- Timeout: timeout=20, tile 3 never sleeps. Expected: timeout_o = 1 exactly 20 cycles after RUN entry; tiles_done_o = 4'b0111; done_o = 0.
- Done/timeout tie: all tiles complete in the same cycle the timeout expires -> done_o = 1, timeout_o = 0.
- Abort mid-RELEASE: abort_i asserted after 2 tiles are released -> next cycle all enables and busy_o are 0, state is IDLE; start_i held high during abort is ignored.
- Async reset in RUN and restart from DONE: rst_i asserted mid-cycle -> outputs 0 without a clock edge. start_i in DONE -> tiles_done cleared; fetch_enable 0 for one cycle, then re-sequenced with the newly latched stagger.
